// File: rtl/div_pkg.sv
// Shared types and helpers for the restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, ITER, DONE} div_state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  // One 4-bit ripple-carry slice: returns {carry_out, sum}.
  function automatic logic [4:0] add4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [4:0] s;
    logic       c;
    c = cin;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    s[4] = c;
    return s;
  endfunction

endpackage

// File: rtl/trial_subtract.sv
// Combinational a - b as a + ~b + 1 over chained 4-bit ripple slices; carry out = no borrow.
module trial_subtract
  import div_pkg::*;
#(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         no_borrow
);

  localparam int unsigned NS = (W + 3) / 4;
  localparam int unsigned N  = NS * 4;

  logic [N-1:0] a_ext, b_inv, sum;
  logic [N-1:0] unused_sum;
  logic         carry [NS+1];

  // Zero-extend both operands; the padded ones of ~b keep the final carry equal to (a >= b).
  always_comb begin
    a_ext        = '0;
    a_ext[W-1:0] = a;
    b_inv        = '1;
    b_inv[W-1:0] = ~b;
  end

  assign carry[0] = 1'b1;

  for (genvar s = 0; s < NS; s++) begin : g_slice
    assign {carry[s+1], sum[4*s +: 4]} = add4(a_ext[4*s +: 4], b_inv[4*s +: 4], carry[s]);
  end

  assign diff       = sum[W-1:0];
  assign no_borrow  = carry[NS];
  assign unused_sum = sum;

endmodule

// File: rtl/restoring_divider.sv
// Sequential restoring divider, one shift/trial-subtract per cycle.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivZero
);

  localparam int unsigned CW = cnt_width(WIDTH);

  div_state_t       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] r_q, q_q, dvsr_q;
  logic [WIDTH:0]   r_shift, t;
  logic             no_borrow, unused_t_msb;
  logic [WIDTH-1:0] r_next, q_next, q_fin, r_fin, dividend_mag, divisor_mag;

  // Partial remainder is widened by one bit so the shifted-out MSB is never lost.
  trial_subtract #(.W(WIDTH + 1)) u_trial (
    .a         (r_shift),
    .b         ({1'b0, dvsr_q}),
    .diff      (t),
    .no_borrow (no_borrow)
  );

  assign unused_t_msb = t[WIDTH];

  always_comb begin
    r_shift = {r_q, q_q[WIDTH-1]};
    r_next  = no_borrow ? t[WIDTH-1:0] : r_shift[WIDTH-1:0];
    q_next  = {q_q[WIDTH-2:0], no_borrow};
  end

`ifdef DIVIDER_SIGNED_EN
  logic neg_q, neg_r;

  always_comb begin
    dividend_mag = Dividend[WIDTH-1] ? -Dividend : Dividend;
    divisor_mag  = Divisor[WIDTH-1] ? -Divisor : Divisor;
    q_fin        = neg_q ? -q_next : q_next;
    r_fin        = neg_r ? -r_next : r_next;
  end
`else
  always_comb begin
    dividend_mag = Dividend;
    divisor_mag  = Divisor;
    q_fin        = q_next;
    r_fin        = r_next;
  end
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      count     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      dvsr_q    <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      DivZero   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            Busy <= 1'b1;
            if (Divisor == '0) begin
              Quotient  <= '1;
              Remainder <= Dividend;
              DivZero   <= 1'b1;
              Done      <= 1'b1;
              state     <= DONE;
            end else begin
              r_q    <= '0;
              q_q    <= dividend_mag;
              dvsr_q <= divisor_mag;
              count  <= '0;
`ifdef DIVIDER_SIGNED_EN
              neg_q  <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
              neg_r  <= Dividend[WIDTH-1];
`endif
              state  <= ITER;
            end
          end
        end
        ITER: begin
          r_q   <= r_next;
          q_q   <= q_next;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            Quotient  <= q_fin;
            Remainder <= r_fin;
            DivZero   <= 1'b0;
            Done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
